// File: rtl/galaxian_input_ctrl.sv
// Player-input front end for the galaxian core: PS/2 key decode, joystick merge,
// display-rotation remap and coin pulse shaping with a lockout gap.
//
// coin FSM states (one per chute)
//   state   | meaning
//   C_IDLE  | waiting for a coin request
//   C_PULSE | coin output high for COIN_PULSE_CYC cycles
//   C_GAP   | coin output forced low for COIN_GAP_CYC cycles
//   C_HOLD  | waiting for the request to drop before re-arming
module galaxian_input_ctrl #(
    parameter int COIN_PULSE_CYC = 1200000,
    parameter int COIN_GAP_CYC   = 1200000,
    parameter bit AUTO_COIN      = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        no_rotate,
    output logic [6:0]  p1_csjudlr,
    output logic [6:0]  p2_csjudlr,
    output logic        service
);

    localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP_CYC - 1);

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP, C_HOLD} coin_state_t;

    logic prev_toggle;
    logic key_event;
    logic k_up, k_down, k_left, k_right, k_fire1, k_start1, k_start2, k_coin1, k_coin2;
    logic k2_up, k2_down, k2_left, k2_right, k_fire2, k_service;

    logic [15:0] joy;
    logic [3:0]  src1_udlr, src2_udlr, rot1_udlr, rot2_udlr;
    logic        start1_src, start2_src, fire1_src;
    logic [1:0]  coin_req;
    logic        unused_joy;

    logic [5:0]  p1_q, p2_q;
    logic        service_q;

    coin_state_t     coin_st  [2];
    logic [CW-1:0]   coin_cnt [2];
    logic [1:0]      coin_q;

    assign key_event = ps2_key[10] != prev_toggle;

    always_ff @(posedge clk_sys) begin
        prev_toggle <= ps2_key[10];
        if (reset) begin
            k_up <= 1'b0; k_down <= 1'b0; k_left <= 1'b0; k_right <= 1'b0;
            k_fire1 <= 1'b0; k_start1 <= 1'b0; k_start2 <= 1'b0;
            k_coin1 <= 1'b0; k_coin2 <= 1'b0;
            k2_up <= 1'b0; k2_down <= 1'b0; k2_left <= 1'b0; k2_right <= 1'b0;
            k_fire2 <= 1'b0; k_service <= 1'b0;
        end else if (key_event) begin
            // arrows arrive with or without the extended prefix, so ignore bit 8
            case (ps2_key[7:0])
                8'h75:   k_up    <= ps2_key[9];
                8'h72:   k_down  <= ps2_key[9];
                8'h6B:   k_left  <= ps2_key[9];
                8'h74:   k_right <= ps2_key[9];
                default: ;
            endcase
            case (ps2_key[8:0])
                9'h029, 9'h014: k_fire1   <= ps2_key[9];
                9'h005, 9'h016: k_start1  <= ps2_key[9];
                9'h006, 9'h01E: k_start2  <= ps2_key[9];
                9'h02E:         k_coin1   <= ps2_key[9];
                9'h036:         k_coin2   <= ps2_key[9];
                9'h02D:         k2_up     <= ps2_key[9];
                9'h02B:         k2_down   <= ps2_key[9];
                9'h023:         k2_left   <= ps2_key[9];
                9'h034:         k2_right  <= ps2_key[9];
                9'h01C:         k_fire2   <= ps2_key[9];
                9'h02C:         k_service <= ps2_key[9];
                default:        ;
            endcase
        end
    end

    function automatic logic [3:0] rotate(input logic [3:0] udlr, input logic rot);
        // horizontal display: up<-left, down<-right, left<-down, right<-up
        return rot ? {udlr[1], udlr[0], udlr[2], udlr[3]} : udlr;
    endfunction

    always_comb begin
        joy        = joystick_0 | joystick_1;
        src1_udlr  = {k_up | joy[3], k_down | joy[2], k_left | joy[1], k_right | joy[0]};
        src2_udlr  = {k2_up | joy[3], k2_down | joy[2], k2_left | joy[1], k2_right | joy[0]};
        rot1_udlr  = rotate(src1_udlr, no_rotate);
        rot2_udlr  = rotate(src2_udlr, no_rotate);
        fire1_src  = k_fire1 | joy[4];
        start1_src = k_start1 | joy[5];
        start2_src = k_start2 | joy[6];
        coin_req[0] = k_coin1 | joy[7] | (AUTO_COIN & (start1_src | start2_src));
        coin_req[1] = k_coin2 | joy[8];
        unused_joy = &{1'b0, joy[15:9]};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p1_q      <= '0;
            p2_q      <= '0;
            service_q <= 1'b0;
        end else begin
            p1_q      <= {start1_src, fire1_src, rot1_udlr};
            p2_q      <= {start2_src, k_fire2, rot2_udlr};
            service_q <= k_service;
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                coin_st[i]  <= C_IDLE;
                coin_cnt[i] <= '0;
                coin_q[i]   <= 1'b0;
            end else begin
                case (coin_st[i])
                    C_IDLE: begin
                        coin_cnt[i] <= '0;
                        if (coin_req[i]) begin
                            coin_st[i] <= C_PULSE;
                            coin_q[i]  <= 1'b1;
                        end
                    end
                    C_PULSE: begin
                        if (coin_cnt[i] == PULSE_LAST) begin
                            coin_st[i]  <= C_GAP;
                            coin_cnt[i] <= '0;
                            coin_q[i]   <= 1'b0;
                        end else begin
                            coin_cnt[i] <= coin_cnt[i] + 1'b1;
                        end
                    end
                    C_GAP: begin
                        coin_q[i] <= 1'b0;
                        if (coin_cnt[i] == GAP_LAST) begin
                            coin_st[i]  <= C_HOLD;
                            coin_cnt[i] <= '0;
                        end else begin
                            coin_cnt[i] <= coin_cnt[i] + 1'b1;
                        end
                    end
                    C_HOLD: begin
                        coin_q[i]   <= 1'b0;
                        coin_cnt[i] <= '0;
                        if (!coin_req[i]) coin_st[i] <= C_IDLE;
                    end
                    default: begin
                        coin_st[i]  <= C_IDLE;
                        coin_cnt[i] <= '0;
                        coin_q[i]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign p1_csjudlr = {coin_q[0], p1_q};
    assign p2_csjudlr = {coin_q[1], p2_q};
    assign service    = service_q;

endmodule
